ir_word_loader: RTL and testbench
=================================

// Module: ir_word_loader
// PURPOSE
//  Operator-driven program loader; the write-side counterpart of the hex readout path.
//  Assembles 16-bit instruction words one nibble at a time from switches and a step key.
//  Writes each completed word to processor instruction memory via a req/ack port, then
//  auto-increments the address. Sits beside Processor at board top level; shares HEX displays.
// PARAMETERS
//  DATA_W          16      instruction word width, fixed multiple of 4
//  ADDR_W          8       instruction memory address width; matches PC width
//  DEBOUNCE_CYCLES 50000   consecutive stable cycles required on Key_n
// PORTS
//  Clk        in  1       system clock
//  Reset_n    in  1       synchronous, active-low reset
//  Key_n      in  1       raw step key, active-low, asynchronous to Clk
//  Nibble_In  in  4       nibble value from switches, sampled on step
//  Addr_Clr   in  1       1-cycle pulse: address:=0, partial word discarded
//  Mem_Req    out 1       memory transaction request
//  Mem_We     out 1       1=write, 0=read; valid while Mem_Req
//  Mem_Addr   out ADDR_W  transaction address; also current load address
//  Mem_Wdata  out DATA_W  write data
//  Mem_Ack    in  1       memory completes transaction in cycle sampled high
//  Mem_Rdata  in  DATA_W  read data, valid with Mem_Ack (used only with readback)
//  Word_Disp  out DATA_W  partial word shift register, for HEX display
//  Nib_Cnt    out 2       nibbles collected in current word (0..3)
//  Busy       out 1       1 when not in S_COLLECT
//  Err        out 1       sticky readback mismatch flag
// BEHAVIOUR
//  Reset (Reset_n low at posedge): all outputs 0, state S_COLLECT, debounce idle.
//  Step: Key_n -> 2-flop sync -> debounce. One 1-cycle pulse per press.
//   Pulse fires when sync'd level low for DEBOUNCE_CYCLES consecutive cycles.
//   Re-arms only after DEBOUNCE_CYCLES consecutive high. Glitches shorter reset the count.
//  S_COLLECT on step:
//   Word_Disp <= {Word_Disp[DATA_W-5:0], Nibble_In}, MSB nibble first.
//   Nib_Cnt increments. On 4th step: Mem_Wdata <= completed word, Word_Disp <= 0,
//   Nib_Cnt <= 0, next state S_WRITE.
//  S_WRITE: Mem_Req=1, Mem_We=1. Mem_Addr and Mem_Wdata stable until Ack.
//   Ack seen (incl. first Req cycle): Req drops next cycle. Next state S_ADV.
//  S_ADV (1 cycle): Mem_Addr <= Mem_Addr+1, wraps 2^ADDR_W-1 -> 0. Next state S_COLLECT.
//  Latency: 4th step pulse -> Mem_Req high on next cycle.
//   Ack -> next step accepted 2 cycles later.
//  Steps while Busy: dropped, no effect, no queueing.
//  Addr_Clr in S_COLLECT: Mem_Addr, Word_Disp, Nib_Cnt, Err <= 0.
//   Addr_Clr when Busy: ignored. Same-cycle step + Addr_Clr: Addr_Clr wins, step dropped.
//  Mem_Ack outside a request: ignored.
//  Reset mid-transaction: Req drops next cycle; partial word lost.
// CONFIGURATION
//  LOADER_READBACK_EN defined:
//   S_WRITE ack -> S_READ: Req=1, We=0, same address.
//   On Ack, Mem_Rdata != Mem_Wdata sets Err (sticky). Then S_ADV.
//  LOADER_READBACK_EN undefined:
//   No S_READ; Err tied 0; Mem_Rdata unused; Mem_We=1 whenever Req.
// STRUCTURE
//  loader_pkg: state enum (S_COLLECT, S_WRITE, S_READ, S_ADV), NIB_PER_WORD=DATA_W/4,
//   default widths.
//  Sub-module key_pulse: synchronizer + debounce counter + press-edge pulse,
//   parameter DEBOUNCE_CYCLES.
// TESTING (bench uses DEBOUNCE_CYCLES=4)
//  1. Reset, press nibbles 1,2,3,4; ack Req after 2 cycles.
//   -> one write: Addr=0x00, Wdata=0x1234. Then Mem_Addr=0x01, Busy=0.
//  2. Key_n 2-cycle low glitch, then clean press with Nibble_In=0xA.
//   -> exactly one step: Nib_Cnt=1, Word_Disp=0x000A.
//  3. Load 256 words, Ack in same cycle as Req.
//   -> addresses 0x00..0xFF, then Mem_Addr wraps to 0x00; each Req exactly 1 cycle.
//  4. Step press during S_WRITE, Ack held off 20 cycles.
//   -> step dropped; after Ack Nib_Cnt=0; Req/Addr/Wdata stable all 20 cycles.
//  5. Two nibbles entered, then Addr_Clr.
//   -> Word_Disp=0, Nib_Cnt=0, Mem_Addr=0; Reset_n low during Req -> Req=0 next cycle.
//  6. [READBACK_EN] write 0xBEEF, return Rdata 0xBEEE.
//   -> Err=1 and stays set through next good word; Addr_Clr clears it.

Source files
------------

// File: rtl/ir_word_loader_pkg.sv
// Shared types and default widths for the nibble-at-a-time instruction loader.
package ir_word_loader_pkg;

    localparam int unsigned DATA_W_DEF       = 16;
    localparam int unsigned ADDR_W_DEF       = 8;
    localparam int unsigned DEBOUNCE_DEF     = 50000;
    localparam int unsigned NIB_PER_WORD     = DATA_W_DEF / 4;

    typedef enum logic [1:0] {
        S_COLLECT,
        S_WRITE,
        S_READ,
        S_ADV
    } loader_state_e;

endpackage

// File: rtl/ir_word_loader_if.sv
// Instruction-memory req/ack port between the loader (master) and memory (slave).
interface ir_word_loader_if
    import ir_word_loader_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) ();

    logic              Mem_Req;
    logic              Mem_We;
    logic [ADDR_W-1:0] Mem_Addr;
    logic [DATA_W-1:0] Mem_Wdata;
    logic              Mem_Ack;
    logic [DATA_W-1:0] Mem_Rdata;

    modport master (
        output Mem_Req, Mem_We, Mem_Addr, Mem_Wdata,
        input  Mem_Ack, Mem_Rdata
    );

    modport slave (
        input  Mem_Req, Mem_We, Mem_Addr, Mem_Wdata,
        output Mem_Ack, Mem_Rdata
    );

endinterface

// File: rtl/ir_word_loader_key_pulse.sv
// Step key conditioner: 2-flop synchronizer, symmetric debounce, one pulse per press.
module ir_word_loader_key_pulse #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic Key_n,
    output logic step
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic [CNT_W-1:0] cnt_q;
    logic             pressed_q;
    logic             pulse_q;

    // Idle counts consecutive lows; pressed counts consecutive highs before re-arming.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            cnt_q     <= '0;
            pressed_q <= 1'b0;
            pulse_q   <= 1'b0;
        end else begin
            sync1_q <= Key_n;
            sync2_q <= sync1_q;
            pulse_q <= 1'b0;
            if (sync2_q == pressed_q) begin
                if (cnt_q == CNT_LAST) begin
                    cnt_q     <= '0;
                    pressed_q <= ~pressed_q;
                    pulse_q   <= ~pressed_q;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign step = pulse_q;

endmodule

// File: rtl/ir_word_loader.sv
// Operator program loader: builds words from switch nibbles and writes them to instruction
// memory with auto-increment. Define LOADER_READBACK_EN to verify each write by reading back.
module ir_word_loader
    import ir_word_loader_pkg::*;
#(
    parameter int unsigned DATA_W          = DATA_W_DEF,
    parameter int unsigned ADDR_W          = ADDR_W_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Key_n,
    input  logic [3:0]        Nibble_In,
    input  logic              Addr_Clr,
    ir_word_loader_if.master  mem,
    output logic [DATA_W-1:0] Word_Disp,
    output logic [1:0]        Nib_Cnt,
    output logic              Busy,
    output logic              Err
);

    localparam logic [1:0] LAST_NIB = 2'(NIB_PER_WORD - 1);

    loader_state_e     state_q;
    logic              step;
    logic              req_q, we_q, err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, word_q;
    logic [1:0]        cnt_q;

    ir_word_loader_key_pulse #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_pulse (
        .Clk    (Clk),
        .Reset_n(Reset_n),
        .Key_n  (Key_n),
        .step   (step)
    );

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q <= S_COLLECT;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            word_q  <= '0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                S_COLLECT: begin
                    // Clear takes priority over a coincident step.
                    if (Addr_Clr) begin
                        addr_q <= '0;
                        word_q <= '0;
                        cnt_q  <= '0;
                        err_q  <= 1'b0;
                    end else if (step) begin
                        if (cnt_q == LAST_NIB) begin
                            wdata_q <= {word_q[DATA_W-5:0], Nibble_In};
                            word_q  <= '0;
                            cnt_q   <= '0;
                            req_q   <= 1'b1;
                            we_q    <= 1'b1;
                            state_q <= S_WRITE;
                        end else begin
                            word_q <= {word_q[DATA_W-5:0], Nibble_In};
                            cnt_q  <= cnt_q + 2'd1;
                        end
                    end
                end
                S_WRITE: begin
                    if (mem.Mem_Ack) begin
`ifdef LOADER_READBACK_EN
                        we_q    <= 1'b0;
                        state_q <= S_READ;
`else
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        state_q <= S_ADV;
`endif
                    end
                end
`ifdef LOADER_READBACK_EN
                S_READ: begin
                    if (mem.Mem_Ack) begin
                        if (mem.Mem_Rdata != wdata_q) begin
                            err_q <= 1'b1;
                        end
                        req_q   <= 1'b0;
                        state_q <= S_ADV;
                    end
                end
`endif
                S_ADV: begin
                    addr_q  <= addr_q + ADDR_W'(1);
                    state_q <= S_COLLECT;
                end
                default: begin
                    req_q   <= 1'b0;
                    we_q    <= 1'b0;
                    state_q <= S_COLLECT;
                end
            endcase
        end
    end

    assign mem.Mem_Req   = req_q;
    assign mem.Mem_We    = we_q;
    assign mem.Mem_Addr  = addr_q;
    assign mem.Mem_Wdata = wdata_q;
    assign Word_Disp     = word_q;
    assign Nib_Cnt       = cnt_q;
    assign Busy          = (state_q != S_COLLECT);
    assign Err           = err_q;

endmodule

// File: tb/tb_ir_word_loader.sv
// Directed bench for ir_word_loader with a small instruction-memory responder.
module tb_ir_word_loader;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       Key_n;
    logic [3:0] Nibble_In;
    logic       Addr_Clr;
    logic [15:0] Word_Disp;
    logic [1:0]  Nib_Cnt;
    logic        Busy;
    logic        Err;

    int checks = 0;
    int errors = 0;

    // Responder controls and transaction log
    logic        ack_en = 1'b1;
    int          ack_delay = 0;
    logic [15:0] rd_mask = 16'h0000;
    logic [15:0] mem_model [256];
    logic [7:0]  log_addr [$];
    logic [15:0] log_data [$];
    int          log_len [$];
    int          req_cycles = 0;

    always #5 Clk = ~Clk;

    ir_word_loader_if #(.DATA_W(16), .ADDR_W(8)) mem_bus ();

    ir_word_loader #(
        .DATA_W         (16),
        .ADDR_W         (8),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .Key_n    (Key_n),
        .Nibble_In(Nibble_In),
        .Addr_Clr (Addr_Clr),
        .mem      (mem_bus),
        .Word_Disp(Word_Disp),
        .Nib_Cnt  (Nib_Cnt),
        .Busy     (Busy),
        .Err      (Err)
    );

    // Memory side: acks once a request has waited ack_delay cycles; logs writes.
    initial begin
        mem_bus.Mem_Ack   = 1'b0;
        mem_bus.Mem_Rdata = '0;
        forever begin
            @(negedge Clk);
            if (mem_bus.Mem_Req && ack_en && req_cycles >= ack_delay) begin
                mem_bus.Mem_Ack = 1'b1;
                if (mem_bus.Mem_We) begin
                    mem_model[mem_bus.Mem_Addr] = mem_bus.Mem_Wdata;
                    log_addr.push_back(mem_bus.Mem_Addr);
                    log_data.push_back(mem_bus.Mem_Wdata);
                    log_len.push_back(req_cycles + 1);
                end else begin
                    mem_bus.Mem_Rdata = mem_model[mem_bus.Mem_Addr] ^ rd_mask;
                end
                req_cycles = 0;
            end else begin
                mem_bus.Mem_Ack = 1'b0;
                if (mem_bus.Mem_Req) req_cycles++;
                else                 req_cycles = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic press(input logic [3:0] nib);
        Nibble_In = nib;
        Key_n = 1'b0;
        tick(10);
        Key_n = 1'b1;
        tick(10);
    endtask

    task automatic load_word(input logic [15:0] w);
        press(w[15:12]);
        press(w[11:8]);
        press(w[7:4]);
        press(w[3:0]);
    endtask

    task automatic clr();
        Addr_Clr = 1'b1;
        tick(1);
        Addr_Clr = 1'b0;
        tick(1);
    endtask

    initial begin
        logic [15:0] w;
        logic        exp_err;
`ifdef LOADER_READBACK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        for (int i = 0; i < 256; i++) mem_model[i] = '0;

        Reset_n   = 1'b0;
        Key_n     = 1'b1;
        Nibble_In = 4'h0;
        Addr_Clr  = 1'b0;
        tick(3);
        check("rst_req", mem_bus.Mem_Req, 0);
        check("rst_we", mem_bus.Mem_We, 0);
        check("rst_addr", mem_bus.Mem_Addr, 0);
        check("rst_wdata", mem_bus.Mem_Wdata, 0);
        check("rst_word", Word_Disp, 0);
        check("rst_cnt", Nib_Cnt, 0);
        check("rst_busy", Busy, 0);
        check("rst_err", Err, 0);
        Reset_n = 1'b1;
        tick(2);

        // 1: one word, ack two cycles into the request
        ack_delay = 2;
        press(4'h1);
        press(4'h2);
        press(4'h3);
        check("t1_word3", Word_Disp, 16'h0123);
        check("t1_cnt3", Nib_Cnt, 3);
        press(4'h4);
        check("t1_nwrites", log_addr.size(), 1);
        check("t1_addr", log_addr[0], 8'h00);
        check("t1_data", log_data[0], 16'h1234);
        check("t1_len", log_len[0], 3);
        check("t1_next_addr", mem_bus.Mem_Addr, 8'h01);
        check("t1_busy", Busy, 0);
        check("t1_word", Word_Disp, 0);
        check("t1_cnt", Nib_Cnt, 0);

        // 2: short glitch must not step; clean press does
        Nibble_In = 4'h5;
        Key_n = 1'b0;
        tick(2);
        Key_n = 1'b1;
        tick(10);
        check("t2_glitch_cnt", Nib_Cnt, 0);
        check("t2_glitch_word", Word_Disp, 0);
        press(4'hA);
        check("t2_cnt", Nib_Cnt, 1);
        check("t2_word", Word_Disp, 16'h000A);

        clr();
        check("clr_word", Word_Disp, 0);
        check("clr_cnt", Nib_Cnt, 0);
        check("clr_addr", mem_bus.Mem_Addr, 0);

        // 3: fill all 256 addresses with same-cycle ack, then wrap
        ack_delay = 0;
        log_addr.delete();
        log_data.delete();
        log_len.delete();
        for (int i = 0; i < 256; i++) begin
            w = {i[7:0], ~i[7:0]};
            load_word(w);
        end
        check("t3_nwrites", log_addr.size(), 256);
        for (int i = 0; i < 256; i++) begin
            w = {i[7:0], ~i[7:0]};
            check("t3_addr", log_addr[i], i[7:0]);
            check("t3_data", log_data[i], w);
            check("t3_len", log_len[i], 1);
        end
        check("t3_wrap", mem_bus.Mem_Addr, 8'h00);
        check("t3_busy", Busy, 0);

        // 4: step during a stalled write is dropped; port stays stable
        ack_en = 1'b0;
        load_word(16'hC0DE);
        check("t4_req", mem_bus.Mem_Req, 1);
        check("t4_busy", Busy, 1);
        Nibble_In = 4'h7;
        Key_n = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick(1);
            if (k == 9) Key_n = 1'b1;
            check("t4_hold_req", mem_bus.Mem_Req, 1);
            check("t4_hold_we", mem_bus.Mem_We, 1);
            check("t4_hold_addr", mem_bus.Mem_Addr, 8'h00);
            check("t4_hold_wdata", mem_bus.Mem_Wdata, 16'hC0DE);
        end
        ack_en = 1'b1;
        tick(8);
        check("t4_data", log_data[log_data.size()-1], 16'hC0DE);
        check("t4_cnt", Nib_Cnt, 0);
        check("t4_word", Word_Disp, 0);
        check("t4_busy", Busy, 0);
        check("t4_addr", mem_bus.Mem_Addr, 8'h01);

        // 5: clear discards a partial word; reset drops an outstanding request
        press(4'h1);
        press(4'h2);
        check("t5_word", Word_Disp, 16'h0012);
        check("t5_cnt", Nib_Cnt, 2);
        clr();
        check("t5_clr_word", Word_Disp, 0);
        check("t5_clr_cnt", Nib_Cnt, 0);
        check("t5_clr_addr", mem_bus.Mem_Addr, 0);
        ack_en = 1'b0;
        load_word(16'h5555);
        check("t5_req_up", mem_bus.Mem_Req, 1);
        Reset_n = 1'b0;
        tick(1);
        check("t5_rst_req", mem_bus.Mem_Req, 0);
        check("t5_rst_busy", Busy, 0);
        check("t5_rst_wdata", mem_bus.Mem_Wdata, 0);
        Reset_n = 1'b1;
        ack_en = 1'b1;
        tick(2);
        check("t5_err_clean", Err, 0);

        // 6: corrupted readback sets a sticky error that only clear removes
        rd_mask = 16'h0001;
        load_word(16'hBEEF);
        check("t6_data", log_data[log_data.size()-1], 16'hBEEF);
        check("t6_err", Err, exp_err);
        rd_mask = 16'h0000;
        load_word(16'h1111);
        check("t6_err_sticky", Err, exp_err);
        check("t6_addr", mem_bus.Mem_Addr, 8'h02);
        clr();
        check("t6_err_clr", Err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
